// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with EX-side operand forwarding
//                (EX/MEM over MEM/WB over register file) and load-use
//                hazard detection driving a one-cycle ID/IF stall.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Id_valid,
  input  logic [DATA_W-1:0] Id_rs_val,
  input  logic [DATA_W-1:0] Id_rt_val,
  input  logic [DATA_W-1:0] Id_imm,
  input  logic [REG_AW-1:0] Id_rs,
  input  logic [REG_AW-1:0] Id_rt,
  input  logic [REG_AW-1:0] Id_rd,
  input  logic              Id_uses_rs,
  input  logic              Id_uses_rt,
  input  logic [OP_W-1:0]   Id_alu_op,
  input  logic              Id_alu_src,
  input  logic              Id_reg_write,
  input  logic              Id_mem_read,
  input  logic              Id_mem_write,
  input  logic              Ex_mem_reg_write,
  input  logic [REG_AW-1:0] Ex_mem_rd,
  input  logic [DATA_W-1:0] Ex_mem_result,
  input  logic              Mem_wb_reg_write,
  input  logic [REG_AW-1:0] Mem_wb_rd,
  input  logic [DATA_W-1:0] Mem_wb_result,
  input  logic              Mem_stall,
  input  logic              Flush,
  output logic [DATA_W-1:0] A_in,
  output logic [DATA_W-1:0] B_in,
  output logic [OP_W-1:0]   Alu_op,
  output logic [DATA_W-1:0] Ex_store_data,
  output logic [REG_AW-1:0] Ex_rd,
  output logic              Ex_valid,
  output logic              Ex_reg_write,
  output logic              Ex_mem_read,
  output logic              Ex_mem_write,
  output logic              Id_stall
);

  // Pipeline registers holding the instruction currently in EX.
  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_alu_src;
  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_rs_val;
  logic [DATA_W-1:0] r_rt_val;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;

  // Forwarded operand values.
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Hazard terms.
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_stall;

  // Load-use hazard: a load in EX whose destination is read by the
  // instruction in ID. The load result only exists after MEM, so ID must
  // wait one cycle; after the bubble the load sits in EX/MEM (then MEM/WB)
  // and ordinary forwarding supplies the value.
  always_comb begin
    w_rs_hit = Id_uses_rs && (Id_rs == r_rd);
    w_rt_hit = Id_uses_rt && (Id_rt == r_rd);
    w_stall  = !Reset && !Flush && r_valid && r_mem_read &&
               (r_rd != '0) && Id_valid && (w_rs_hit || w_rt_hit);
  end

  // Register update: reset > flush > hold > load-use bubble > load.
  // A flush wins over the hold so a killed instruction never lingers in EX.
  always_ff @(posedge Clk) begin
    if (Reset || Flush || (!Mem_stall && w_stall)) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= '0;
      r_rs_val    <= '0;
      r_rt_val    <= '0;
      r_imm       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
    end else if (!Mem_stall) begin
      r_valid     <= Id_valid;
      r_reg_write <= Id_reg_write && Id_valid;
      r_mem_read  <= Id_mem_read  && Id_valid;
      r_mem_write <= Id_mem_write && Id_valid;
      r_alu_src   <= Id_alu_src;
      r_alu_op    <= Id_alu_op;
      r_rs_val    <= Id_rs_val;
      r_rt_val    <= Id_rt_val;
      r_imm       <= Id_imm;
      r_rs        <= Id_rs;
      r_rt        <= Id_rt;
      r_rd        <= Id_rd;
    end
  end

  // Operand A forwarding: newest producer first; register 0 is never forwarded.
  always_comb begin
    w_fwd_rs = r_rs_val;
    if (r_rs != '0) begin
      if (Ex_mem_reg_write && (Ex_mem_rd == r_rs)) begin
        w_fwd_rs = Ex_mem_result;
      end else if (Mem_wb_reg_write && (Mem_wb_rd == r_rs)) begin
        w_fwd_rs = Mem_wb_result;
      end
    end
  end

  // Operand rt forwarding, shared by ALU operand B and store data.
  always_comb begin
    w_fwd_rt = r_rt_val;
    if (r_rt != '0) begin
      if (Ex_mem_reg_write && (Ex_mem_rd == r_rt)) begin
        w_fwd_rt = Ex_mem_result;
      end else if (Mem_wb_reg_write && (Mem_wb_rd == r_rt)) begin
        w_fwd_rt = Mem_wb_result;
      end
    end
  end

  // Output drive: ALU operands, store data and registered control.
  always_comb begin
    A_in          = w_fwd_rs;
    B_in          = r_alu_src ? r_imm : w_fwd_rt;
    Ex_store_data = w_fwd_rt;
    Alu_op        = r_alu_op;
    Ex_rd         = r_rd;
    Ex_valid      = r_valid;
    Ex_reg_write  = r_reg_write;
    Ex_mem_read   = r_mem_read;
    Ex_mem_write  = r_mem_write;
    Id_stall      = w_stall;
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage: vector table for
//                load/forwarding, directed sequences for reset, load-use
//                stall, hold and flush.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Id_valid;
  logic [31:0] Id_rs_val, Id_rt_val, Id_imm;
  logic [4:0]  Id_rs, Id_rt, Id_rd;
  logic        Id_uses_rs, Id_uses_rt;
  logic [3:0]  Id_alu_op;
  logic        Id_alu_src, Id_reg_write, Id_mem_read, Id_mem_write;
  logic        Ex_mem_reg_write;
  logic [4:0]  Ex_mem_rd;
  logic [31:0] Ex_mem_result;
  logic        Mem_wb_reg_write;
  logic [4:0]  Mem_wb_rd;
  logic [31:0] Mem_wb_result;
  logic        Mem_stall, Flush;
  logic [31:0] A_in, B_in, Ex_store_data;
  logic [3:0]  Alu_op;
  logic [4:0]  Ex_rd;
  logic        Ex_valid, Ex_reg_write, Ex_mem_read, Ex_mem_write, Id_stall;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .OP_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Id_valid(Id_valid),
    .Id_rs_val(Id_rs_val), .Id_rt_val(Id_rt_val), .Id_imm(Id_imm),
    .Id_rs(Id_rs), .Id_rt(Id_rt), .Id_rd(Id_rd),
    .Id_uses_rs(Id_uses_rs), .Id_uses_rt(Id_uses_rt),
    .Id_alu_op(Id_alu_op), .Id_alu_src(Id_alu_src),
    .Id_reg_write(Id_reg_write), .Id_mem_read(Id_mem_read), .Id_mem_write(Id_mem_write),
    .Ex_mem_reg_write(Ex_mem_reg_write), .Ex_mem_rd(Ex_mem_rd), .Ex_mem_result(Ex_mem_result),
    .Mem_wb_reg_write(Mem_wb_reg_write), .Mem_wb_rd(Mem_wb_rd), .Mem_wb_result(Mem_wb_result),
    .Mem_stall(Mem_stall), .Flush(Flush),
    .A_in(A_in), .B_in(B_in), .Alu_op(Alu_op), .Ex_store_data(Ex_store_data),
    .Ex_rd(Ex_rd), .Ex_valid(Ex_valid), .Ex_reg_write(Ex_reg_write),
    .Ex_mem_read(Ex_mem_read), .Ex_mem_write(Ex_mem_write), .Id_stall(Id_stall)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Id_valid = 0; Id_rs_val = 0; Id_rt_val = 0; Id_imm = 0;
    Id_rs = 0; Id_rt = 0; Id_rd = 0; Id_uses_rs = 0; Id_uses_rt = 0;
    Id_alu_op = 0; Id_alu_src = 0; Id_reg_write = 0; Id_mem_read = 0; Id_mem_write = 0;
    Ex_mem_reg_write = 0; Ex_mem_rd = 0; Ex_mem_result = 0;
    Mem_wb_reg_write = 0; Mem_wb_rd = 0; Mem_wb_result = 0;
    Mem_stall = 0; Flush = 0;
  endtask

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val, imm;
    logic [3:0]  op;
    logic        src, rw, mr, mw;
    logic        emw;  logic [4:0] emrd; logic [31:0] emres;
    logic        mww;  logic [4:0] mwrd; logic [31:0] mwres;
    logic [31:0] ea, eb, est;
    logic        ev, erw, emwo;
  } vec_t;

  vec_t v[8];

  initial begin
    // valid rs rt rd rs_val rt_val imm op src rw mr mw | emw emrd emres | mww mwrd mwres | A B store | ev erw emw
    v[0] = '{1, 1, 2, 3, 32'h5,  32'h7,    32'h0,   4'h2, 0, 1, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,
             32'h5,    32'h7,   32'h7,    1, 1, 0};
    v[1] = '{1, 4, 5, 10, 32'h99, 32'h55,  32'h100, 4'h3, 1, 1, 0, 0, 1, 4, 32'h11, 1, 4, 32'h22,
             32'h11,   32'h100, 32'h55,   1, 1, 0};
    v[2] = '{1, 4, 5, 10, 32'h99, 32'h55,  32'h100, 4'h3, 1, 1, 0, 0, 0, 4, 32'h11, 1, 4, 32'h22,
             32'h22,   32'h100, 32'h55,   1, 1, 0};
    v[3] = '{1, 0, 0, 1, 32'h0,  32'h0,    32'h0,   4'h5, 0, 1, 0, 0, 1, 0, 32'h33, 1, 0, 32'h44,
             32'h0,    32'h0,   32'h0,    1, 1, 0};
    v[4] = '{1, 7, 6, 2, 32'h10, 32'h1,    32'h0,   4'h6, 0, 1, 0, 0, 1, 6, 32'hAB, 1, 7, 32'hCD,
             32'hCD,   32'hAB,  32'hAB,   1, 1, 0};
    v[5] = '{0, 1, 2, 3, 32'hA,  32'hB,    32'hC,   4'h1, 1, 1, 0, 1, 0, 0, 32'h0,  0, 0, 32'h0,
             32'hA,    32'hC,   32'hB,    0, 0, 0};
    v[6] = '{1, 9, 9, 0, 32'h5,  32'h1234, 32'h8,   4'h7, 1, 0, 0, 1, 0, 0, 32'h0,  1, 9, 32'h4321,
             32'h4321, 32'h8,   32'h4321, 1, 0, 1};
    v[7] = '{1, 3, 3, 4, 32'h31, 32'h31,   32'h0,   4'h8, 0, 1, 0, 0, 0, 3, 32'h1,  0, 3, 32'h2,
             32'h31,   32'h31,  32'h31,   1, 1, 0};

    clear_inputs();
    Reset = 1;
    tick(); tick();
    chk("rst_valid", {31'b0, Ex_valid}, 0);
    chk("rst_rw",    {31'b0, Ex_reg_write}, 0);
    chk("rst_mr",    {31'b0, Ex_mem_read}, 0);
    chk("rst_mw",    {31'b0, Ex_mem_write}, 0);
    chk("rst_op",    {28'b0, Alu_op}, 0);
    chk("rst_rd",    {27'b0, Ex_rd}, 0);
    chk("rst_a",     A_in, 0);
    chk("rst_b",     B_in, 0);
    chk("rst_st",    Ex_store_data, 0);
    chk("rst_stall", {31'b0, Id_stall}, 0);
    Reset = 0;

    // Table: load one instruction, then apply forwarding sources and check.
    for (int i = 0; i < 8; i++) begin
      Id_valid = v[i].valid; Id_rs = v[i].rs; Id_rt = v[i].rt; Id_rd = v[i].rd;
      Id_rs_val = v[i].rs_val; Id_rt_val = v[i].rt_val; Id_imm = v[i].imm;
      Id_alu_op = v[i].op; Id_alu_src = v[i].src; Id_reg_write = v[i].rw;
      Id_mem_read = v[i].mr; Id_mem_write = v[i].mw;
      Id_uses_rs = 1; Id_uses_rt = 1;
      tick();
      Ex_mem_reg_write = v[i].emw; Ex_mem_rd = v[i].emrd; Ex_mem_result = v[i].emres;
      Mem_wb_reg_write = v[i].mww; Mem_wb_rd = v[i].mwrd; Mem_wb_result = v[i].mwres;
      #1;
      chk($sformatf("v%0d_a", i),     A_in, v[i].ea);
      chk($sformatf("v%0d_b", i),     B_in, v[i].eb);
      chk($sformatf("v%0d_st", i),    Ex_store_data, v[i].est);
      chk($sformatf("v%0d_op", i),    {28'b0, Alu_op}, {28'b0, v[i].op});
      chk($sformatf("v%0d_rd", i),    {27'b0, Ex_rd}, {27'b0, v[i].rd});
      chk($sformatf("v%0d_valid", i), {31'b0, Ex_valid}, {31'b0, v[i].ev});
      chk($sformatf("v%0d_rw", i),    {31'b0, Ex_reg_write}, {31'b0, v[i].erw});
      chk($sformatf("v%0d_mw", i),    {31'b0, Ex_mem_write}, {31'b0, v[i].emwo});
    end

    // Mid-stream reset with a load in EX and a dependent instruction in ID.
    clear_inputs();
    Id_valid = 1; Id_mem_read = 1; Id_reg_write = 1; Id_rd = 8; Id_rs = 1; Id_rs_val = 32'h40;
    tick();
    Id_mem_read = 0; Id_rd = 9; Id_rt = 8; Id_uses_rt = 1; Id_rs_val = 32'h3;
    #1;
    chk("lu_pre_reset_stall", {31'b0, Id_stall}, 1);
    Reset = 1;
    #1;
    chk("reset_masks_stall", {31'b0, Id_stall}, 0);
    tick();
    chk("midrst_valid", {31'b0, Ex_valid}, 0);
    chk("midrst_rw",    {31'b0, Ex_reg_write}, 0);
    chk("midrst_a",     A_in, 0);
    chk("midrst_b",     B_in, 0);
    chk("midrst_stall", {31'b0, Id_stall}, 0);
    Reset = 0;

    // Load-use: lw r8 then addu r9,r2,r8 -> one stall, one bubble, then forward.
    clear_inputs();
    Id_valid = 1; Id_mem_read = 1; Id_reg_write = 1; Id_rd = 8; Id_rs = 1; Id_rs_val = 32'h40;
    Id_alu_src = 1; Id_imm = 32'h4; Id_uses_rs = 1;
    tick();
    chk("lw_mr", {31'b0, Ex_mem_read}, 1);
    chk("lw_rd", {27'b0, Ex_rd}, 8);
    chk("lw_b",  B_in, 32'h4);
    Id_mem_read = 0; Id_alu_src = 0; Id_imm = 0; Id_rd = 9;
    Id_rs = 2; Id_rs_val = 32'h3; Id_rt = 8; Id_rt_val = 32'h0; Id_uses_rs = 1; Id_uses_rt = 1;
    #1;
    chk("lu_stall", {31'b0, Id_stall}, 1);
    tick();
    chk("lu_bubble_valid", {31'b0, Ex_valid}, 0);
    chk("lu_bubble_rw",    {31'b0, Ex_reg_write}, 0);
    chk("lu_bubble_stall", {31'b0, Id_stall}, 0);
    Ex_mem_reg_write = 1; Ex_mem_rd = 8; Ex_mem_result = 32'h77;
    tick();
    chk("lu_cons_valid", {31'b0, Ex_valid}, 1);
    chk("lu_cons_rd",    {27'b0, Ex_rd}, 9);
    chk("lu_cons_a",     A_in, 32'h3);
    chk("lu_cons_b",     B_in, 32'h77);
    chk("lu_cons_stall", {31'b0, Id_stall}, 0);

    // Load-use with rs dependence, suppressed by Flush.
    clear_inputs();
    Id_valid = 1; Id_mem_read = 1; Id_reg_write = 1; Id_rd = 6;
    tick();
    Id_mem_read = 0; Id_rs = 6; Id_uses_rs = 1; Id_rd = 7;
    #1;
    chk("lu_rs_stall", {31'b0, Id_stall}, 1);
    Flush = 1;
    #1;
    chk("flush_masks_stall", {31'b0, Id_stall}, 0);
    tick();
    chk("flush_valid", {31'b0, Ex_valid}, 0);
    Flush = 0;

    // Hold: sw in EX, Mem_stall for 3 cycles while ID changes underneath.
    clear_inputs();
    Id_valid = 1; Id_mem_write = 1; Id_rs = 1; Id_rs_val = 32'h200; Id_rt = 5; Id_rt_val = 32'hBEEF;
    Id_imm = 32'h10; Id_alu_src = 1; Id_alu_op = 4'h2;
    tick();
    chk("sw_mw", {31'b0, Ex_mem_write}, 1);
    Mem_stall = 1;
    Id_mem_write = 0; Id_reg_write = 1; Id_rs_val = 32'h1; Id_rt_val = 32'h2; Id_rd = 12;
    Id_alu_src = 0; Id_alu_op = 4'h9;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d_valid", c), {31'b0, Ex_valid}, 1);
      chk($sformatf("hold%0d_mw", c),    {31'b0, Ex_mem_write}, 1);
      chk($sformatf("hold%0d_rw", c),    {31'b0, Ex_reg_write}, 0);
      chk($sformatf("hold%0d_st", c),    Ex_store_data, 32'hBEEF);
      chk($sformatf("hold%0d_a", c),     A_in, 32'h200);
      chk($sformatf("hold%0d_b", c),     B_in, 32'h10);
      chk($sformatf("hold%0d_op", c),    {28'b0, Alu_op}, 32'h2);
    end
    Flush = 1;
    tick();
    chk("stallflush_valid", {31'b0, Ex_valid}, 0);
    chk("stallflush_mw",    {31'b0, Ex_mem_write}, 0);
    chk("stallflush_st",    Ex_store_data, 0);
    Flush = 0; Mem_stall = 0;
    tick();
    chk("resume_valid", {31'b0, Ex_valid}, 1);
    chk("resume_rd",    {27'b0, Ex_rd}, 12);
    chk("resume_op",    {28'b0, Alu_op}, 32'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
